// File: rtl/chunked_addsub_if.sv
// Operand/result bus for chunked_addsub: valid/ready operand side and valid/ready result side.
interface chunked_addsub_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output in_valid, A, B, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow
    );

    modport slave (
        input  in_valid, A, B, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, overflow
    );
endinterface

// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: CHUNK bits per cycle, LSB first, carry held in a register between chunks.
module chunked_addsub #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input logic              clk,
    input logic              rst_n,
    chunked_addsub_if.slave  bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("chunked_addsub: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK:0]   chunk_res;
    logic [WIDTH-1:0] part_next;

    // Operands shift right one chunk per cycle; results enter at the top and drift down to their final place.
    assign chunk_res = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
    assign part_next = (part_q >> CHUNK) | (WIDTH'(chunk_res[CHUNK-1:0]) << (WIDTH - CHUNK));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        part_d  = part_q;
        a_d     = a_q;
        b_d     = b_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.A;
                    b_d     = bus.sub ? ~bus.B : bus.B;
                    carry_d = bus.c_in ^ bus.sub;
                    a_msb_d = bus.A[WIDTH-1];
                    b_msb_d = bus.sub ? ~bus.B[WIDTH-1] : bus.B[WIDTH-1];
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                part_d  = part_next;
                carry_d = chunk_res[CHUNK];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NCHUNK - 1)) begin
                    sum_d   = part_next;
                    c_out_d = chunk_res[CHUNK];
                    ovf_d   = (a_msb_q == b_msb_q) && (part_next[WIDTH-1] != a_msb_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            part_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            part_q  <= part_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) && rst_n;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_chunked_addsub.sv
// Directed and random checks of chunked_addsub at 64/16, 8/8 and 32/4 against a signed/unsigned arithmetic model.
module tb_chunked_addsub;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    chunked_addsub_if #(.WIDTH(64)) if64 ();
    chunked_addsub_if #(.WIDTH(8))  if8  ();
    chunked_addsub_if #(.WIDTH(32)) if32 ();

    chunked_addsub #(.WIDTH(64), .CHUNK(16)) u64 (.clk(clk), .rst_n(rst_n), .bus(if64));
    chunked_addsub #(.WIDTH(8),  .CHUNK(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    chunked_addsub #(.WIDTH(32), .CHUNK(4))  u32 (.clk(clk), .rst_n(rst_n), .bus(if32));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic on wide signed values, then reduce modulo 2^w.
    function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic c, input logic s,
                                  output logic [63:0] sm, output logic co, output logic ov);
        logic [63:0]        mask, am, bm;
        logic signed [67:0] sa, sb, sr, ur, lim, cc;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        am   = a & mask;
        bm   = b & mask;
        cc   = $signed({67'd0, c});
        sa   = $signed({4'd0, am});
        sb   = $signed({4'd0, bm});
        ur   = s ? (sa - sb - cc) : (sa + sb + cc);
        if (am[w-1]) sa = sa - (68'sd1 <<< w);
        if (bm[w-1]) sb = sb - (68'sd1 <<< w);
        sr   = s ? (sa - sb - cc) : (sa + sb + cc);
        lim  = 68'sd1 <<< (w - 1);
        ov   = (sr >= lim) || (sr < -lim);
        sm   = ur[63:0] & mask;
        co   = s ? (ur >= 0) : ur[w];
    endfunction

    task automatic drive(input int sel, input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic c, input logic s);
        case (sel)
            0: begin if64.in_valid = v; if64.A = a;       if64.B = b;       if64.c_in = c; if64.sub = s; end
            1: begin if8.in_valid  = v; if8.A  = a[7:0];  if8.B  = b[7:0];  if8.c_in  = c; if8.sub  = s; end
            default: begin if32.in_valid = v; if32.A = a[31:0]; if32.B = b[31:0]; if32.c_in = c; if32.sub = s; end
        endcase
    endtask

    task automatic sample(input int sel, output logic rdy, output logic vld, output logic [63:0] sm,
                          output logic co, output logic ov);
        case (sel)
            0: begin rdy = if64.in_ready; vld = if64.out_valid; sm = if64.sum; co = if64.c_out; ov = if64.overflow; end
            1: begin rdy = if8.in_ready; vld = if8.out_valid; sm = 64'(if8.sum); co = if8.c_out; ov = if8.overflow; end
            default: begin rdy = if32.in_ready; vld = if32.out_valid; sm = 64'(if32.sum); co = if32.c_out; ov = if32.overflow; end
        endcase
    endtask

    // One transaction: wait for ready, accept, count cycles to out_valid, compare with the model.
    task automatic op(input int sel, input int w, input int nch, input logic [63:0] a, input logic [63:0] b,
                      input logic c, input logic s, input string tag,
                      output logic [63:0] rs, output logic rco, output logic rov);
        logic rdy, vld;
        logic [63:0] es;
        logic eco, eov;
        int n, lat;
        drive(sel, 1'b1, a, b, c, s);
        sample(sel, rdy, vld, rs, rco, rov);
        n = 0;
        while (!rdy && n < 50) begin
            @(posedge clk); #1;
            sample(sel, rdy, vld, rs, rco, rov);
            n++;
        end
        chk({tag, "_accept"}, 64'(rdy), 64'd1);
        @(posedge clk); #1;
        drive(sel, 1'b0, a, b, c, s);
        lat = 0;
        sample(sel, rdy, vld, rs, rco, rov);
        while (!vld && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            sample(sel, rdy, vld, rs, rco, rov);
        end
        chk({tag, "_latency"}, 64'(lat), 64'(nch));
        model(w, a, b, c, s, es, eco, eov);
        chk({tag, "_sum"}, rs, es);
        chk({tag, "_cout"}, 64'(rco), 64'(eco));
        chk({tag, "_ovf"}, 64'(rov), 64'(eov));
    endtask

    initial begin
        logic [63:0] rs, held, ra, rb;
        logic rco, rov, rc, rsub;
        logic rdy, vld, co_s, ov_s;
        logic [63:0] sm_s;

        if64.out_ready = 1'b1; if8.out_ready = 1'b1; if32.out_ready = 1'b1;
        drive(1, 1'b0, '0, '0, 1'b0, 1'b0);
        drive(2, 1'b0, '0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        drive(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);

        // Reset held two cycles with in_valid asserted.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst_in_ready", 64'(if64.in_ready), 64'd0);
            chk("rst_out_valid", 64'(if64.out_valid), 64'd0);
            chk("rst_sum", if64.sum, 64'd0);
            chk("rst_cout", 64'(if64.c_out), 64'd0);
            chk("rst_ovf", 64'(if64.overflow), 64'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 64'(if64.in_ready), 64'd1);

        op(0, 64, 4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, "ripple", rs, rco, rov);
        chk("ripple_sum_k", rs, 64'd0);
        chk("ripple_cout_k", 64'(rco), 64'd1);
        chk("ripple_ovf_k", 64'(rov), 64'd0);

        op(0, 64, 4, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, "ovf_add", rs, rco, rov);
        chk("ovf_add_sum_k", rs, 64'h8000_0000_0000_0000);
        chk("ovf_add_cout_k", 64'(rco), 64'd0);
        chk("ovf_add_ovf_k", 64'(rov), 64'd1);

        op(0, 64, 4, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, "ovf_sub", rs, rco, rov);
        chk("ovf_sub_sum_k", rs, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("ovf_sub_cout_k", 64'(rco), 64'd1);
        chk("ovf_sub_ovf_k", 64'(rov), 64'd1);

        op(0, 64, 4, 64'd5, 64'd7, 1'b0, 1'b1, "borrow", rs, rco, rov);
        chk("borrow_sum_k", rs, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("borrow_cout_k", 64'(rco), 64'd0);
        chk("borrow_ovf_k", 64'(rov), 64'd0);

        op(0, 64, 4, 64'd5, 64'd7, 1'b1, 1'b1, "borrow_cin", rs, rco, rov);
        chk("borrow_cin_sum_k", rs, 64'hFFFF_FFFF_FFFF_FFFD);

        // Backpressure: result held in DONE while a new operand is offered and must be ignored.
        @(posedge clk); #1;
        if64.out_ready = 1'b0;
        op(0, 64, 4, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, "bp_first", held, rco, rov);
        chk("bp_first_sum_k", held, 64'h2222_2222_2222_2212);
        drive(0, 1'b1, 64'd100, 64'd58, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(if64.out_valid), 64'd1);
            chk("bp_sum_stable", if64.sum, held);
            chk("bp_in_ready", 64'(if64.in_ready), 64'd0);
        end
        if64.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 64'(if64.out_valid), 64'd0);
        chk("bp_release_ready", 64'(if64.in_ready), 64'd1);
        chk("bp_release_sum", if64.sum, held);
        op(0, 64, 4, 64'd100, 64'd58, 1'b0, 1'b1, "bp_second", rs, rco, rov);
        chk("bp_second_sum_k", rs, 64'd42);

        // Reset two cycles into RUN abandons the operation.
        @(posedge clk); #1;
        drive(0, 1'b1, 64'd3, 64'd4, 1'b0, 1'b0);
        sample(0, rdy, vld, sm_s, co_s, ov_s);
        chk("midrst_ready", 64'(rdy), 64'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 64'd3, 64'd4, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("midrst_valid_low", 64'(if64.out_valid), 64'd0);
        end
        chk("midrst_sum", if64.sum, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_valid", 64'(if64.out_valid), 64'd0);
            chk("midrst_idle", 64'(if64.in_ready), 64'd1);
        end

        // Random sweep on all three geometries.
        for (int sel = 0; sel < 3; sel++) begin
            int w, nch, nops;
            w    = (sel == 0) ? 64 : (sel == 1) ? 8 : 32;
            nch  = (sel == 0) ? 4 : (sel == 1) ? 1 : 8;
            nops = (sel == 0) ? 300 : 1000;
            for (int i = 0; i < nops; i++) begin
                ra   = {$urandom(), $urandom()};
                rb   = {$urandom(), $urandom()};
                if ($urandom_range(0, 7) == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
                if ($urandom_range(0, 7) == 0) rb = {1'b0, {63{1'b1}}} >> (64 - w);
                rc   = 1'($urandom_range(0, 1));
                rsub = 1'($urandom_range(0, 1));
                op(sel, w, nch, ra, rb, rc, rsub, "rand", rs, rco, rov);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
